// File: rtl/counter_ctrl_if.sv
// Control/status bundle for counter_ctrl: request inputs from the controller side
// and registered status returned by the counter block.
interface counter_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int RW    = 4
);
    // start is a one-edge request, not a valid/ready pair: it is accepted only in IDLE/DONE
    // with a non-zero limit (busy rises next cycle), refused with cfg_err when limit is zero,
    // and silently dropped in RUN/HOLD or when halt is asserted on the same edge.
    logic             start;
    logic             halt;
    logic             hold;
    logic             auto_reload;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] counter;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [RW-1:0]    rounds;

    modport master (
        output start, halt, hold, auto_reload, limit,
        input  counter, busy, done, cfg_err, rounds
    );

    modport slave (
        input  start, halt, hold, auto_reload, limit,
        output counter, busy, done, cfg_err, rounds
    );
endinterface

// File: rtl/counter_ctrl.sv
// One-shot / periodic terminal counter with hold, abort and a saturating count of
// completed periods. Every status output comes straight from a register.
module counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int RW    = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    counter_ctrl_if.slave       bus,
    // FSM state for observation: 0 IDLE, 1 RUN, 2 HOLD, 3 DONE
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_counter;
    logic [WIDTH-1:0] w_counter_nxt;
    logic [WIDTH-1:0] r_lim;
    logic [WIDTH-1:0] w_lim_nxt;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_cfg_err;
    logic             w_cfg_err_nxt;
    logic [RW-1:0]    r_rounds;
    logic [RW-1:0]    w_rounds_nxt;

    logic             w_can_start;
    logic             w_limit_ok;
    logic             w_terminal;
    logic             w_rounds_max;

    assign w_can_start  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_limit_ok   = (bus.limit != '0);
    assign w_terminal   = (r_counter == r_lim);
    assign w_rounds_max = (r_rounds == '1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_counter <= '0;
            r_lim     <= '0;
            r_mode    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_rounds  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_lim     <= w_lim_nxt;
            r_mode    <= w_mode_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            r_rounds  <= w_rounds_nxt;
        end
    end

    // Edge priority: halt, then start acceptance, then hold, then terminal count, then increment.
    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_lim_nxt     = r_lim;
        w_mode_nxt    = r_mode;
        w_done_nxt    = 1'b0;
        w_cfg_err_nxt = 1'b0;
        w_rounds_nxt  = r_rounds;

        if (bus.halt) begin
            w_state_nxt   = S_IDLE;
            w_counter_nxt = '0;
        end else if (w_can_start && bus.start) begin
            if (w_limit_ok) begin
                w_state_nxt   = S_RUN;
                w_counter_nxt = '0;
                w_lim_nxt     = bus.limit;
                w_mode_nxt    = bus.auto_reload;
                w_rounds_nxt  = '0;
            end else begin
                w_cfg_err_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.hold) begin
                        w_state_nxt = S_HOLD;
                    end else if (w_terminal) begin
                        w_done_nxt = 1'b1;
                        if (!w_rounds_max) begin
                            w_rounds_nxt = r_rounds + 1'b1;
                        end
                        if (r_mode) begin
                            w_counter_nxt = '0;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_counter_nxt = r_counter + 1'b1;
                    end
                end
                // Release only changes state; the frozen value advances on the following edge.
                S_HOLD: begin
                    if (!bus.hold) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(r_done && r_cfg_err));
            assert (r_counter <= r_lim);
        end
    end

    assign bus.counter = r_counter;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.cfg_err = r_cfg_err;
    assign bus.rounds  = r_rounds;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios with literal expectations plus random
// stimulus, all checked every cycle against a behavioural model.
module tb_counter_ctrl;
    localparam int WIDTH = 4;
    localparam int RW    = 4;
    localparam int RMAX  = (1 << RW) - 1;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    counter_ctrl_if #(.WIDTH(WIDTH), .RW(RW)) bus ();

    counter_ctrl #(.WIDTH(WIDTH), .RW(RW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: state as a phase number, count and rounds as plain integers.
    int m_state  = M_IDLE;
    int m_count  = 0;
    int m_lim    = 0;
    int m_rounds = 0;
    bit m_mode   = 1'b0;
    bit m_done   = 1'b0;
    bit m_cfg    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_state = M_IDLE; m_count = 0; m_lim = 0; m_rounds = 0;
            m_mode = 1'b0; m_done = 1'b0; m_cfg = 1'b0;
        end else begin
            m_done = 1'b0;
            m_cfg  = 1'b0;
            if (bus.halt) begin
                m_state = M_IDLE;
                m_count = 0;
            end else if (bus.start && (m_state == M_IDLE || m_state == M_DONE)) begin
                if (int'(bus.limit) == 0) begin
                    m_cfg = 1'b1;
                end else begin
                    m_lim = int'(bus.limit); m_mode = bus.auto_reload;
                    m_count = 0; m_rounds = 0; m_state = M_RUN;
                end
            end else if (m_state == M_RUN) begin
                if (bus.hold) m_state = M_HOLD;
                else if (m_count == m_lim) begin
                    m_done = 1'b1;
                    m_rounds = (m_rounds + 1 > RMAX) ? RMAX : m_rounds + 1;
                    if (m_mode) m_count = 0;
                    else m_state = M_DONE;
                end else m_count = m_count + 1;
            end else if (m_state == M_HOLD && !bus.hold) begin
                m_state = M_RUN;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if ($isunknown({bus.counter, bus.busy, bus.done, bus.cfg_err, bus.rounds, dbg_state}) ||
                32'(bus.counter) != m_count || 32'(bus.rounds) != m_rounds ||
                32'(dbg_state) != m_state || bus.done != m_done || bus.cfg_err != m_cfg ||
                bus.busy != (m_state == M_RUN || m_state == M_HOLD)) begin
                n_fail++;
                $display("FAIL model t=%0t: got cnt=%0d rnd=%0d st=%0d busy=%b done=%b cfg=%b want cnt=%0d rnd=%0d st=%0d busy=%b done=%b cfg=%b",
                         $time, bus.counter, bus.rounds, dbg_state, bus.busy, bus.done, bus.cfg_err,
                         m_count, m_rounds, m_state, (m_state == M_RUN || m_state == M_HOLD), m_done, m_cfg);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit st, input bit ht, input bit hd, input bit ar, input int lim);
        bus.start       = st;
        bus.halt        = ht;
        bus.hold        = hd;
        bus.auto_reload = ar;
        bus.limit       = lim[WIDTH-1:0];
    endtask

    int seq35 [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};

    initial begin
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        step(2);
        chk_en = 1'b1;
        lit("rst cnt", bus.counter, 0);
        lit("rst busy", bus.busy, 0);
        lit("rst rounds", bus.rounds, 0);
        lit("rst state", dbg_state, 0);
        rst = 1'b0;
        step(1);

        // one-shot, limit 3
        drive(1, 0, 0, 0, 3); step(1);
        lit("os e0 cnt", bus.counter, 0); lit("os e0 busy", bus.busy, 1);
        drive(0, 0, 0, 0, 3);
        step(1); lit("os e1 cnt", bus.counter, 1);
        step(1); lit("os e2 cnt", bus.counter, 2);
        step(1); lit("os e3 cnt", bus.counter, 3); lit("os e3 done", bus.done, 0);
        step(1);
        lit("os e4 done", bus.done, 1); lit("os e4 busy", bus.busy, 0);
        lit("os e4 cnt", bus.counter, 3); lit("os e4 rounds", bus.rounds, 1);
        lit("os e4 state", dbg_state, M_DONE);
        step(1); lit("os e5 done", bus.done, 0); lit("os e5 cnt", bus.counter, 3);

        // periodic, limit 2
        drive(1, 0, 0, 1, 2); step(1);
        lit("per e0 cnt", bus.counter, 0); lit("per e0 rounds", bus.rounds, 0);
        drive(0, 0, 0, 0, 9);
        for (int i = 1; i < 9; i++) begin
            step(1);
            lit($sformatf("per e%0d cnt", i), bus.counter, seq35[i]);
            lit($sformatf("per e%0d done", i), bus.done, (i == 3 || i == 6) ? 1 : 0);
        end
        lit("per rounds", bus.rounds, 2);

        // abort keeps rounds, then hold behaviour with limit 5 periodic
        drive(0, 1, 0, 0, 0); step(1);
        lit("halt state", dbg_state, M_IDLE); lit("halt cnt", bus.counter, 0);
        lit("halt rounds kept", bus.rounds, 2);
        drive(1, 0, 0, 1, 5); step(1);
        lit("hold start rounds", bus.rounds, 0);
        drive(0, 0, 0, 0, 5); step(2);
        lit("hold pre cnt", bus.counter, 2);
        drive(0, 0, 1, 0, 5);
        for (int i = 0; i < 3; i++) begin
            step(1);
            lit("hold cnt", bus.counter, 2); lit("hold state", dbg_state, M_HOLD);
            lit("hold busy", bus.busy, 1);
        end
        drive(0, 0, 0, 0, 5); step(1);
        lit("release state", dbg_state, M_RUN); lit("release cnt", bus.counter, 2);
        step(1); lit("resume cnt3", bus.counter, 3);
        step(1); lit("resume cnt4", bus.counter, 4);
        step(1); lit("resume cnt5", bus.counter, 5);
        drive(0, 0, 1, 0, 5); step(1);
        lit("hold@term state", dbg_state, M_HOLD); lit("hold@term done", bus.done, 0);
        step(1); lit("hold@term done2", bus.done, 0);
        drive(0, 0, 0, 0, 5); step(1);
        lit("rel@term done", bus.done, 0); lit("rel@term cnt", bus.counter, 5);
        step(1);
        lit("term done", bus.done, 1); lit("term cnt", bus.counter, 0);
        lit("term rounds", bus.rounds, 1);

        // config error and start ignored while running
        drive(0, 1, 0, 0, 0); step(1);
        drive(1, 0, 0, 0, 0); step(1);
        lit("cfg pulse", bus.cfg_err, 1); lit("cfg state", dbg_state, M_IDLE);
        lit("cfg cnt", bus.counter, 0);
        drive(0, 0, 0, 0, 0); step(1);
        lit("cfg clear", bus.cfg_err, 0);
        drive(1, 0, 0, 0, 4); step(1);
        lit("run4 cnt", bus.counter, 0);
        drive(1, 0, 0, 1, 1); step(1);
        lit("ign cnt", bus.counter, 1); lit("ign cfg", bus.cfg_err, 0);
        drive(0, 0, 0, 0, 0); step(3);
        lit("ign cnt4", bus.counter, 4); lit("ign done0", bus.done, 0);
        step(1);
        lit("ign done", bus.done, 1); lit("ign state", dbg_state, M_DONE);
        drive(1, 0, 0, 0, 0); step(1);
        lit("cfg in done", bus.cfg_err, 1); lit("cfg done state", dbg_state, M_DONE);
        lit("cfg done cnt", bus.counter, 4);

        // halt+start collision, then reset mid-run
        drive(1, 0, 0, 1, 7); step(1);
        drive(0, 0, 0, 0, 7); step(4);
        lit("abort pre cnt", bus.counter, 4);
        drive(1, 1, 0, 1, 7); step(1);
        lit("abort state", dbg_state, M_IDLE); lit("abort cnt", bus.counter, 0);
        lit("abort done", bus.done, 0); lit("abort busy", bus.busy, 0);
        drive(1, 0, 0, 1, 7); step(1);
        drive(0, 0, 0, 0, 7); step(2);
        rst = 1'b1; step(1); rst = 1'b0;
        lit("rst run cnt", bus.counter, 0); lit("rst run busy", bus.busy, 0);
        lit("rst run state", dbg_state, M_IDLE); lit("rst run rounds", bus.rounds, 0);

        // rounds saturation with limit 1 periodic
        drive(1, 0, 0, 1, 1); step(1);
        drive(0, 0, 0, 0, 1);
        for (int i = 1; i <= 40; i++) begin
            step(1);
            lit($sformatf("sat e%0d done", i), bus.done, (i % 2 == 0) ? 1 : 0);
            lit($sformatf("sat e%0d rounds", i), bus.rounds, (i / 2 > 15) ? 15 : i / 2);
        end

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)));
            step(1);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
